// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped, flop-based branch target buffer with 2-bit saturating
// direction counters for the 5-stage RV32I pipeline. It supplies a predicted
// next PC to the IF-stage PC-select mux every cycle. It learns from branches
// and jumps resolved in EX, and it reports mispredictions plus the correct
// redirect PC.
//
// Ports
//   i_clk, i_rst_n     clock / asynchronous active-low reset
//   i_if_pc            PC being fetched (lookup address)
//   o_pred_taken       predicted taken for i_if_pc (combinational)
//   o_pred_pc          predicted next PC for i_if_pc (combinational)
//   i_upd_*            resolution of a branch/jump in EX
//   o_mispred          combinational mispredict flag for the current update
//   o_redirect_pc      correct next PC for the current update
//   o_br_cnt           saturating count of accepted updates (registered)
//   o_miss_cnt         saturating count of mispredictions (registered)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_pc,
    input  logic        i_upd_vld,
    input  logic        i_upd_jmp,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_pc,
    output logic        o_mispred,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Saturating helpers
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    function automatic logic [31:0] cnt_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Table state
    logic             valid_q  [ENTRIES];
    logic             jmp_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    // Lookup (zero latency, no bypass from a same-cycle update)
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             pred_taken;

    assign if_idx     = i_if_pc[IDX_W+1:2];
    assign if_tag     = i_if_pc[31:IDX_W+2];
    assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    // Gating with reset keeps the fetch path at PC+4 while reset is held,
    // independent of how the table flops settle.
    assign pred_taken = i_rst_n && if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);

    assign o_pred_taken = pred_taken;
    assign o_pred_pc    = pred_taken ? target_q[if_idx] : i_if_pc + 32'd4;

    // Mispredict / redirect
    logic mispred;

    always_comb begin
        mispred = 1'b0;
        if (i_upd_vld) begin
            if (i_upd_taken) mispred = (i_upd_pred_pc != i_upd_target);
            else             mispred = i_upd_pred_taken;
        end
    end

    assign o_mispred     = mispred;
    assign o_redirect_pc = (i_upd_vld && i_upd_taken) ? i_upd_target : i_upd_pc + 32'd4;

    // Update
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                jmp_q[i]    <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (i_upd_vld) begin
            if (upd_hit) begin
                if (i_upd_jmp) begin
                    ctr_q[upd_idx]    <= 2'b11;
                    target_q[upd_idx] <= i_upd_target;
                    jmp_q[upd_idx]    <= 1'b1;
                end else if (i_upd_taken) begin
                    ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
                    target_q[upd_idx] <= i_upd_target;
                end else begin
                    ctr_q[upd_idx]    <= ctr_dec(ctr_q[upd_idx]);
                end
            end else if (i_upd_taken) begin
                // Allocation evicts whatever aliased entry was there.
                valid_q[upd_idx]  <= 1'b1;
                jmp_q[upd_idx]    <= i_upd_jmp;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= i_upd_target;
                ctr_q[upd_idx]    <= i_upd_jmp ? 2'b11 : 2'b10;
            end
        end
    end

    // Statistics counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (i_upd_vld) begin
            br_cnt_q <= cnt_inc(br_cnt_q);
            if (mispred) miss_cnt_q <= cnt_inc(miss_cnt_q);
        end
    end

    assign o_br_cnt   = br_cnt_q;
    assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_vld;
    logic        upd_jmp;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        mispred;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    branch_predictor #(.ENTRIES(16)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_pc        (pred_pc),
        .i_upd_vld        (upd_vld),
        .i_upd_jmp        (upd_jmp),
        .i_upd_pc         (upd_pc),
        .i_upd_taken      (upd_taken),
        .i_upd_target     (upd_target),
        .i_upd_pred_taken (upd_pred_taken),
        .i_upd_pred_pc    (upd_pred_pc),
        .o_mispred        (mispred),
        .o_redirect_pc    (redirect_pc),
        .o_br_cnt         (br_cnt),
        .o_miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_PT = 0, S_PPC = 1, S_MIS = 2, S_RED = 3, S_BR = 4, S_MC = 5;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic expect_lookup(input logic t, input logic [31:0] p, input string nm);
        expect_val(S_PT, {31'd0, t}, {nm, "_taken"});
        expect_val(S_PPC, p, {nm, "_pc"});
    endtask

    task automatic expect_cnt(input logic [31:0] b, input logic [31:0] m, input string nm);
        expect_val(S_BR, b, {nm, "_br_cnt"});
        expect_val(S_MC, m, {nm, "_miss_cnt"});
    endtask

    task automatic expect_upd(input logic mp, input logic [31:0] r, input string nm);
        expect_val(S_MIS, {31'd0, mp}, {nm, "_mispred"});
        expect_val(S_RED, r, {nm, "_redirect"});
    endtask

    task automatic set_upd(input logic v, input logic j, input logic [31:0] pc,
                           input logic t, input logic [31:0] tg,
                           input logic ppt, input logic [31:0] ppc);
        upd_vld        = v;
        upd_jmp        = j;
        upd_pc         = pc;
        upd_taken      = t;
        upd_target     = tg;
        upd_pred_taken = ppt;
        upd_pred_pc    = ppc;
    endtask

    task automatic no_upd();
        set_upd(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Step to just after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are compared on the falling edge, away from updates.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                S_PT:    act = {31'd0, pred_taken};
                S_PPC:   act = pred_pc;
                S_MIS:   act = {31'd0, mispred};
                S_RED:   act = redirect_pc;
                S_BR:    act = br_cnt;
                default: act = miss_cnt;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s got=%h want=%h @%0t", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        if_pc = 32'h0;
        no_upd();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold lookup
        if_pc = 32'h100;
        expect_lookup(1'b0, 32'h104, "cold");
        expect_cnt(0, 0, "cold");
        expect_val(S_MIS, 0, "cold_mispred");

        // First taken resolution; same-cycle lookup still sees the old entry
        step();
        set_upd(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        expect_upd(1'b1, 32'h80, "alloc");
        expect_lookup(1'b0, 32'h104, "nobypass");

        step(); no_upd();
        expect_lookup(1'b1, 32'h80, "trained");
        expect_cnt(1, 1, "trained");

        // Two not-taken: ctr 10 -> 01 -> 00
        step();
        set_upd(1, 0, 32'h100, 0, 32'h0, 1, 32'h80);
        expect_upd(1'b1, 32'h104, "nt1");
        step();
        set_upd(1, 0, 32'h100, 0, 32'h0, 0, 32'h104);
        expect_upd(1'b0, 32'h104, "nt2");
        expect_cnt(2, 2, "nt2");
        step(); no_upd();
        expect_lookup(1'b0, 32'h104, "ctr00");
        expect_cnt(3, 2, "ctr00");

        // Taken once: ctr 01, still predicted not taken
        step();
        set_upd(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        expect_upd(1'b1, 32'h80, "t1");
        step(); no_upd();
        expect_lookup(1'b0, 32'h104, "ctr01");
        expect_cnt(4, 3, "ctr01");

        // Taken again: ctr 10, predicted taken
        step();
        set_upd(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        step(); no_upd();
        expect_lookup(1'b1, 32'h80, "ctr10");
        expect_cnt(5, 4, "ctr10");

        // Aliasing: 0x140 shares index 0 with 0x100
        step();
        set_upd(1, 0, 32'h140, 1, 32'h200, 0, 32'h144);
        expect_upd(1'b1, 32'h200, "alias");
        step(); no_upd();
        expect_lookup(1'b0, 32'h104, "evicted");
        expect_cnt(6, 5, "evicted");
        step(); if_pc = 32'h140;
        expect_lookup(1'b1, 32'h200, "alias_hit");

        // JAL at 0x20 -> 0x400
        step();
        set_upd(1, 1, 32'h20, 1, 32'h400, 0, 32'h24);
        expect_upd(1'b1, 32'h400, "jal");
        step(); no_upd(); if_pc = 32'h20;
        expect_lookup(1'b1, 32'h400, "jal_hit");
        expect_cnt(7, 6, "jal_hit");
        step();
        set_upd(1, 1, 32'h20, 1, 32'h400, 1, 32'h400);
        expect_upd(1'b0, 32'h400, "jal_ok");
        step(); no_upd();
        expect_lookup(1'b1, 32'h400, "jal_again");
        expect_cnt(8, 6, "jal_again");

        // Taken with a stale target counts as a mispredict and retrains
        step();
        set_upd(1, 1, 32'h20, 1, 32'h500, 1, 32'h400);
        expect_upd(1'b1, 32'h500, "tgt_wrong");
        step(); no_upd();
        expect_lookup(1'b1, 32'h500, "tgt_new");
        expect_cnt(9, 7, "tgt_new");

        // Not-taken miss does not allocate
        step();
        set_upd(1, 0, 32'h300, 0, 32'h0, 0, 32'h304);
        expect_upd(1'b0, 32'h304, "nt_miss");
        step();
        set_upd(0, 0, 32'h10, 0, 32'h0, 1, 32'h0);
        if_pc = 32'h300;
        expect_lookup(1'b0, 32'h304, "no_alloc");
        expect_upd(1'b0, 32'h14, "idle");
        expect_cnt(10, 7, "no_alloc");

        // PC+4 wraps
        step(); no_upd(); if_pc = 32'hFFFF_FFFC;
        expect_lookup(1'b0, 32'h0, "wrap");

        // Asynchronous reset in the middle of an update
        step();
        set_upd(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        if_pc = 32'h20;
        expect_lookup(1'b0, 32'h24, "rst_mid");
        expect_cnt(0, 0, "rst_mid");
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            set_upd(1, 0, 32'h20, 1, 32'h80, 0, 32'h24);
            expect_lookup(1'b0, 32'h24, "rst_hold");
            expect_cnt(0, 0, "rst_hold");
        end
        step(); no_upd(); rst_n = 1'b1; if_pc = 32'h140;
        expect_lookup(1'b0, 32'h144, "post_rst");
        expect_cnt(0, 0, "post_rst");
        step();
        expect_lookup(1'b0, 32'h144, "post_rst2");
        expect_cnt(0, 0, "post_rst2");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RV32I pipeline. It sits upstream of the IF stage's PC-select mux and supplies a predicted next PC each cycle. This replaces the fixed "PC+4" fetch, and its per-instruction prediction bit drives the IF-stage mispredict flag. It learns from branches and jumps resolved in EX and reports mispredictions plus the correct redirect PC back to the PC-select and flush logic.

## Interface
- ENTRIES, 16: number of table entries; power of 2, range 4..64.
- IDX_W, $clog2(ENTRIES): index width. Derived; not overridden.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_pc  in  32  PC of the instruction being fetched.
- o_pred_taken  out  1  prediction for i_if_pc; combinational.
- o_pred_pc  out  32  predicted next PC; combinational.
- i_upd_vld  in  1  an instruction resolved in EX this cycle is a branch or jump (JAL, JALR, Bxx).
- i_upd_jmp  in  1  resolved instruction is an unconditional jump.
- i_upd_pc  in  32  PC of the resolved instruction.
- i_upd_taken  in  1  actual outcome.
- i_upd_target  in  32  actual target (ALU result).
- i_upd_pred_taken  in  1  prediction carried down the pipeline for this instruction.
- i_upd_pred_pc  in  32  predicted next PC carried down the pipeline.
- o_mispred  out  1  combinational mispredict for the current update.
- o_redirect_pc  out  32  correct next PC when o_mispred=1.
- o_br_cnt  out  32  count of accepted updates; registered.
- o_miss_cnt  out  32  count of mispredictions; registered.

## Operation
- Each entry holds: valid, jmp flag, tag = pc[31:IDX_W+2], target[31:0], and a 2-bit saturating counter.
- Index is pc[IDX_W+1:2]. pc[1:0] is ignored.
- Lookup:
  - hit = valid & (tag == i_if_pc tag).
  - o_pred_taken = hit & (jmp | ctr[1]).
  - o_pred_pc = o_pred_taken ? target : i_if_pc + 4, wrapping mod 2^32.
- Mispredict:
  - o_mispred = i_upd_vld & (i_upd_taken ? (i_upd_pred_pc != i_upd_target) : i_upd_pred_taken).
  - o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 4.
  - Both outputs are 0 / i_upd_pc+4 when i_upd_vld=0.
- Update, on the clock edge when i_upd_vld=1, indexed by i_upd_pc:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not taken (bounds 00..11). If taken, target <= i_upd_target.
  - Hit, jump: ctr <= 11, target <= i_upd_target, jmp <= 1.
  - Miss and taken: allocate (replace any existing entry). valid=1, tag and target from the update, jmp=i_upd_jmp, ctr = jmp ? 11 : 10.
  - Miss and not taken: no table write.
- Counters:
  - o_br_cnt += 1 per update.
  - o_miss_cnt += 1 when o_mispred=1.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset (asynchronous, any time including mid-update): all valid=0, ctr=01, jmp=0, target=0, tag=0, both counters 0.
  - While in reset, o_pred_taken=0 and o_pred_pc=i_if_pc+4.

## Timing
- Lookup has zero latency: o_pred_* follow i_if_pc within the same cycle.
- Update has one-cycle latency: a write at edge N is visible to lookups from cycle N+1.
- Same-index lookup and update in the same cycle: the lookup returns the pre-update entry. There is no bypass.
- o_mispred and o_redirect_pc are combinational from the update inputs in the same cycle; the pipeline flushes IF/ID and ID/EX on it.
- At most one update per cycle.
- The table is flop-based: no read latency, no RAM inference.
- After reset deassertion, behaviour is identical to cold start.

## Test plan
- Reset then lookup pc=0x100 -> o_pred_taken=0, o_pred_pc=0x104. Counters read 0.
- Update pc=0x100, taken, target=0x80, jmp=0, pred_taken=0 -> o_mispred=1, o_redirect_pc=0x80. Next cycle, lookup 0x100 -> taken, o_pred_pc=0x80, o_miss_cnt=1.
- Same branch: 2 not-taken updates -> ctr 10→01→00; lookup predicts 0x104. Then 1 taken update -> ctr 01, still not taken. A 2nd taken update -> predicts 0x80.
- Aliasing, ENTRIES=16: train 0x100, then update 0x140 (same index, different tag) taken → 0x200. Lookup 0x100 -> miss, 0x104. Lookup 0x140 -> 0x200.
- JAL at 0x20, target 0x400 -> after one update, predicted taken. A subsequent not-taken-looking update is impossible, so ctr stays 11. Correct prediction (pred_pc=0x400) -> o_mispred=0.
- Assert i_rst_n low mid-update with trained entries -> all lookups miss immediately; counters are 0 and stay 0 throughout reset.
